systolic_mac_array: RTL and testbench

- Parameterised output-stationary systolic array of multiply-accumulate processing elements (PEs) for integer matrix multiply C = A·B.
- Row operands (A elements) enter at the left edge and move right; column operands (B elements) enter at the top and move down.
- Each PE(r,c) accumulates C[r][c] locally and exposes it on a flat result bus.
- Sits between an operand-feeding engine (skewed A/B streams) and a result consumer.

---
 rtl/systolic_mac_array.sv | 119 +++++++++++
 tb/tb_systolic_mac_array.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary systolic MAC array: A operands flow east, B operands flow south,
// and each PE accumulates its own C[r][c] with wrap-around integer arithmetic.
module systolic_mac_array #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic [array_height_p-1:0]                         flush_i,
  input  logic [width_p*array_height_p-1:0]                 row_i,
  input  logic [array_height_p-1:0]                         row_valid_i,
  output logic [array_height_p-1:0]                         row_ready_o,
  input  logic [width_p*array_width_p-1:0]                  col_i,
  input  logic [array_width_p-1:0]                          col_valid_i,
  output logic [array_width_p-1:0]                          col_ready_o,
  output logic [width_p*array_width_p*array_height_p-1:0]   z_o,
  output logic [array_width_p*array_height_p-1:0]           z_valid_o,
  input  logic [array_width_p*array_height_p-1:0]           z_yumi_i
);

  // Product and sum both wrap modulo 2^width_p.
  function automatic logic signed [width_p-1:0] mac_wrap(
    input logic signed [width_p-1:0] acc,
    input logic signed [width_p-1:0] a,
    input logic signed [width_p-1:0] b
  );
    logic signed [2*width_p-1:0] prod;
    prod = a * b;
    return acc + prod[width_p-1:0];
  endfunction

  // Ready must read low while reset is held, even though en_i may be high.
  logic en_act;
  assign en_act = en_i & reset_i;

  for (genvar r = 0; r < array_height_p; r++) begin : g_row
    for (genvar c = 0; c < array_width_p; c++) begin : g_col
      localparam int k = r + c * array_height_p;

      logic signed [width_p-1:0] a_q, b_q, acc_q, a_in, b_in, acc_base;
      logic a_vld_q, b_vld_q, z_vld_q;
      logic a_load, b_load, a_rdy, b_rdy, east_rdy, south_rdy, fire, yumi;

      if (c == 0) begin : g_a_edge
        assign a_in           = row_i[width_p*r +: width_p];
        assign a_load         = row_valid_i[r] & a_rdy;
        assign row_ready_o[r] = a_rdy;
      end else begin : g_a_hop
        assign a_in   = g_row[r].g_col[c-1].a_q;
        assign a_load = g_row[r].g_col[c-1].fire;
      end

      if (r == 0) begin : g_b_edge
        assign b_in           = col_i[width_p*c +: width_p];
        assign b_load         = col_valid_i[c] & b_rdy;
        assign col_ready_o[c] = b_rdy;
      end else begin : g_b_hop
        assign b_in   = g_row[r-1].g_col[c].b_q;
        assign b_load = g_row[r-1].g_col[c].fire;
      end

      if (c == array_width_p - 1) begin : g_east_edge
        assign east_rdy = 1'b1;
      end else begin : g_east_pe
        assign east_rdy = g_row[r].g_col[c+1].a_rdy;
      end

      if (r == array_height_p - 1) begin : g_south_edge
        assign south_rdy = 1'b1;
      end else begin : g_south_pe
        assign south_rdy = g_row[r+1].g_col[c].b_rdy;
      end

      assign fire     = en_act & a_vld_q & b_vld_q & east_rdy & south_rdy;
      assign a_rdy    = en_act & (~a_vld_q | fire);
      assign b_rdy    = en_act & (~b_vld_q | fire);
      assign yumi     = z_yumi_i[k] & z_vld_q;
      assign acc_base = yumi ? '0 : acc_q;

      // Operand data carries no reset; the valid bits alone mark occupancy.
      always_ff @(posedge clk_i) begin
        if (a_load) a_q <= a_in;
        if (b_load) b_q <= b_in;
      end

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          a_vld_q <= 1'b0;
          b_vld_q <= 1'b0;
          z_vld_q <= 1'b0;
          acc_q   <= '0;
        end else if (flush_i[r]) begin
          a_vld_q <= 1'b0;
          b_vld_q <= 1'b0;
          z_vld_q <= 1'b0;
          acc_q   <= '0;
        end else if (en_i) begin
          if (a_load)    a_vld_q <= 1'b1;
          else if (fire) a_vld_q <= 1'b0;
          if (b_load)    b_vld_q <= 1'b1;
          else if (fire) b_vld_q <= 1'b0;
          if (fire) begin
            acc_q   <= mac_wrap(acc_base, a_q, b_q);
            z_vld_q <= 1'b1;
          end else if (yumi) begin
            acc_q   <= '0;
            z_vld_q <= 1'b0;
          end
        end
      end

      assign z_o[width_p*k +: width_p] = acc_q;
      assign z_valid_o[k]              = z_vld_q;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: a 2x2 instance for function, handshake and
// control checks, plus a 3x3 instance for a full skewed matrix multiply.
module tb_systolic_mac_array;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic en_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]   flush_i, row_valid_i, row_ready_o, col_valid_i, col_ready_o;
  logic [63:0]  row_i, col_i;
  logic [127:0] z_o;
  logic [3:0]   z_valid_o, z_yumi_i;

  logic [2:0]   f3, rv3, rr3, cv3, cr3;
  logic [95:0]  r3, c3;
  logic [287:0] z3;
  logic [8:0]   zv3, zy3;

  int checks = 0;
  int failures = 0;

  int a3 [3][3] = '{'{70, -17, -43}, '{-58, -7, 40}, '{61, -14, -5}};
  int b3 [3][3] = '{'{-7, 43, -99}, '{30, 98, -93}, '{-8, 91, -31}};
  int c3x[3][3] = '{'{-656, -2569, -4016}, '{-124, 460, 5153}, '{-807, 796, -4582}};

  systolic_mac_array #(.width_p(32), .array_width_p(2), .array_height_p(2)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .row_i(row_i), .row_valid_i(row_valid_i), .row_ready_o(row_ready_o),
    .col_i(col_i), .col_valid_i(col_valid_i), .col_ready_o(col_ready_o),
    .z_o(z_o), .z_valid_o(z_valid_o), .z_yumi_i(z_yumi_i)
  );

  systolic_mac_array #(.width_p(32), .array_width_p(3), .array_height_p(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(f3),
    .row_i(r3), .row_valid_i(rv3), .row_ready_o(rr3),
    .col_i(c3), .col_valid_i(cv3), .col_ready_o(cr3),
    .z_o(z3), .z_valid_o(zv3), .z_yumi_i(zy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] zs(input int k);
    return z_o[32*k +: 32];
  endfunction

  // One-cycle valid pulse on the 2x2 instance, then let the array settle.
  task automatic feed2(input logic [31:0] r1, input logic [31:0] r0, input logic [1:0] rv,
                       input logic [31:0] c1, input logic [31:0] c0, input logic [1:0] cv);
    row_i = {r1, r0};
    row_valid_i = rv;
    col_i = {c1, c0};
    col_valid_i = cv;
    cyc(1);
    row_valid_i = '0;
    col_valid_i = '0;
    cyc(8);
  endtask

  initial begin
    flush_i = '0; row_valid_i = '0; col_valid_i = '0; row_i = '0; col_i = '0; z_yumi_i = '0;
    f3 = '0; rv3 = '0; cv3 = '0; r3 = '0; c3 = '0; zy3 = '0;
    en_i = 1'b1;
    reset_i = 1'b0;
    cyc(2);
    chk("rst_z_nonzero", 32'(z_o != '0), 32'd0);
    chk("rst_z_valid", 32'(z_valid_o), 32'd0);
    chk("rst_row_ready", 32'(row_ready_o), 32'd0);
    chk("rst_col_ready", 32'(col_ready_o), 32'd0);
    reset_i = 1'b1;
    cyc(1);
    chk("idle_row_ready", 32'(row_ready_o), 32'd3);

    // 2x2 skewed multiply
    feed2(0, 44, 2'b01, 0, 22, 2'b01);
    feed2(960, -37, 2'b11, -1, 83, 2'b11);
    feed2(10, 0, 2'b10, 99, 0, 2'b10);
    chk("t1_z00", zs(0), -2103);
    chk("t1_z10", zs(1), 21950);
    chk("t1_z01", zs(2), -3707);
    chk("t1_z11", zs(3), 30);
    chk("t1_valid", 32'(z_valid_o), 32'hF);
    chk("t1_col_ready", 32'(col_ready_o), 32'd3);

    // yumi on slot 0
    z_yumi_i = 4'b0001;
    cyc(1);
    z_yumi_i = '0;
    chk("yumi_z00", zs(0), 0);
    chk("yumi_valid", 32'(z_valid_o), 32'hE);
    chk("yumi_z10", zs(1), 21950);
    chk("yumi_z01", zs(2), -3707);
    chk("yumi_z11", zs(3), 30);

    // flush row 0
    flush_i = 2'b01;
    cyc(1);
    flush_i = '0;
    chk("flush_valid", 32'(z_valid_o), 32'hA);
    chk("flush_z01", zs(2), 0);
    chk("flush_z11", zs(3), 30);

    // enable low: no handshake, no fire, yumi ignored
    en_i = 1'b0;
    row_i = {32'd0, 32'd5}; row_valid_i = 2'b01;
    col_i = {32'd0, 32'd6}; col_valid_i = 2'b01;
    z_yumi_i = 4'b0010;
    #1;
    chk("en0_row_ready", 32'(row_ready_o), 32'd0);
    chk("en0_col_ready", 32'(col_ready_o), 32'd0);
    cyc(3);
    chk("en0_valid", 32'(z_valid_o), 32'hA);
    chk("en0_z10", zs(1), 21950);
    row_valid_i = '0; col_valid_i = '0; z_yumi_i = '0;
    en_i = 1'b1;
    cyc(3);
    chk("en1_z00", zs(0), 0);
    chk("en1_valid", 32'(z_valid_o), 32'hA);

    // wrap-around arithmetic from a clean array
    flush_i = 2'b11;
    cyc(1);
    flush_i = '0;
    chk("flush_all_valid", 32'(z_valid_o), 32'd0);
    feed2(0, 32'h7FFF_FFFF, 2'b01, 0, 2, 2'b01);
    chk("ovf_z00", zs(0), 32'hFFFF_FFFE);
    chk("ovf_valid", 32'(z_valid_o), 32'd1);

    // asynchronous reset between clock edges
    #2;
    reset_i = 1'b0;
    #1;
    chk("arst_z_nonzero", 32'(z_o != '0), 32'd0);
    chk("arst_valid", 32'(z_valid_o), 32'd0);
    chk("arst_row_ready", 32'(row_ready_o), 32'd0);
    chk("arst_col_ready", 32'(col_ready_o), 32'd0);
    cyc(1);
    reset_i = 1'b1;
    cyc(1);

    // second 2x2 multiply
    feed2(0, 13, 2'b01, 0, 83, 2'b01);
    feed2(6, 45, 2'b11, 9, 22, 2'b11);
    feed2(27, 0, 2'b10, 1, 0, 2'b10);
    chk("t2_z00", zs(0), 2069);
    chk("t2_z10", zs(1), 1092);
    chk("t2_z01", zs(2), 162);
    chk("t2_z11", zs(3), 81);

    reset_i = 1'b0;
    cyc(2);
    reset_i = 1'b1;
    cyc(1);

    // back-pressure: row 0 fed twice with no column operand
    row_i = {32'd0, 32'd5}; row_valid_i = 2'b01;
    cyc(1);
    row_i = {32'd0, 32'd7};
    chk("bp_ready_stall", 32'(row_ready_o[0]), 32'd0);
    cyc(4);
    chk("bp_ready_held", 32'(row_ready_o[0]), 32'd0);
    chk("bp_no_fire", 32'(z_valid_o), 32'd0);
    col_i = {32'd0, 32'd3}; col_valid_i = 2'b01;
    cyc(1);
    col_valid_i = '0;
    for (int i = 0; i < 20 && !row_ready_o[0]; i++) cyc(1);
    chk("bp_ready_return", 32'(row_ready_o[0]), 32'd1);
    cyc(1);
    row_valid_i = '0;
    col_i = {32'd0, 32'd4}; col_valid_i = 2'b01;
    cyc(1);
    col_valid_i = '0;
    cyc(4);
    chk("bp_z00_blocked", zs(0), 15);
    feed2(1, 0, 2'b10, 1, 0, 2'b10);
    chk("bp_z00", zs(0), 43);
    chk("bp_z10", zs(1), 3);
    chk("bp_z01", zs(2), 5);
    chk("bp_z11", zs(3), 1);

    // 3x3 skewed multiply
    for (int s = 0; s < 5; s++) begin
      rv3 = '0;
      cv3 = '0;
      for (int r = 0; r < 3; r++)
        if (s - r >= 0 && s - r < 3) begin
          r3[32*r +: 32] = a3[r][s-r];
          rv3[r] = 1'b1;
        end
      for (int c = 0; c < 3; c++)
        if (s - c >= 0 && s - c < 3) begin
          c3[32*c +: 32] = b3[s-c][c];
          cv3[c] = 1'b1;
        end
      cyc(1);
      rv3 = '0;
      cv3 = '0;
      cyc(8);
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("t3_c%0d%0d", r, c), z3[32*(r + 3*c) +: 32], c3x[r][c]);
    chk("t3_valid", 32'(zv3), 32'h1FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
